// File: rtl/ysyx_25020032_lsu_pkg.sv
// Shared encodings for the load/store unit: access widths (RISC-V funct3),
// FSM state encoding and the alignment check used when an instruction is accepted.
package ysyx_25020032_lsu_pkg;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

   // Halfwords need an even address, words a 4-byte aligned one; bytes never fault.
   function automatic logic is_misaligned(input logic [2:0] width, input logic [1:0] offset);
      logic mis;
      mis = 1'b0;
      case (width)
         LSU_H, LSU_HU: mis = offset[0];
         LSU_W:         mis = (offset != 2'b00);
         default:       mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/ysyx_25020032_load_ext.sv
// Load data alignment: shifts the addressed lane of the memory word down to
// bit 0 and sign- or zero-extends it according to the access width.
module ysyx_25020032_load_ext
   import ysyx_25020032_lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      offset,
   input  logic [2:0]      width,
   output logic [XLEN-1:0] result
);

   logic [XLEN-1:0] shifted;

   assign shifted = rdata >> {offset, 3'b000};

   // Select the extension for the requested width; word (and unknown) passes through.
   always_comb begin
      result = shifted;
      case (width)
         LSU_B:   result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         LSU_BU:  result = {{(XLEN-8){1'b0}}, shifted[7:0]};
         LSU_H:   result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         LSU_HU:  result = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: result = shifted;
      endcase
   end

endmodule

// File: rtl/ysyx_25020032_lsu.sv
// Load/store unit between execute and write-back. Accepts one instruction at a
// time, runs a single request/response on the data-memory port, and hands the
// extended load data (or the pass-through ALU result) to write-back.
module ysyx_25020032_lsu
   import ysyx_25020032_lsu_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int XLEN    = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            exu_valid,
   output logic            lsu_ready,
   output logic            lsu_valid,
   input  logic            wbu_ready,
   input  logic            mem_ren,
   input  logic            mem_wen,
   input  logic [2:0]      mem_width,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wdata,
   input  logic [3:0]      wmask,
   input  logic [XLEN-1:0] alu_res,
   output logic            dmem_req_valid,
   input  logic            dmem_req_ready,
   output logic            dmem_req_wen,
   output logic [XLEN-1:0] dmem_req_addr,
   output logic [XLEN-1:0] dmem_req_wdata,
   output logic [3:0]      dmem_req_wmask,
   input  logic            dmem_resp_valid,
   input  logic [XLEN-1:0] dmem_resp_rdata,
   output logic [XLEN-1:0] wb_data,
   output logic            lsu_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

   lsu_state_e      state_q;
   logic            lsu_ready_q;
   logic            lsu_valid_q;
   logic            req_valid_q;
   logic [XLEN-1:0] wb_data_q;
   logic            err_q;
   logic [CNT_W-1:0] cnt_q;

   // Latched copy of the accepted instruction.
   logic            ren_q;
   logic            wen_q;
   logic [2:0]      width_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [3:0]      wmask_q;
   logic [XLEN-1:0] alu_q;

   logic [XLEN-1:0] load_data;
   logic            timeout_hit;
   logic [CNT_W-1:0] cnt_inc;

   ysyx_25020032_load_ext #(.XLEN(XLEN)) u_load_ext (
      .rdata  (dmem_resp_rdata),
      .offset (addr_q[1:0]),
      .width  (width_q),
      .result (load_data)
   );

   // Counter saturates so a late handshake can never wrap it back below the limit.
   assign cnt_inc     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
   assign timeout_hit = (cnt_q >= CNT_LAST);

   assign lsu_ready      = lsu_ready_q;
   assign lsu_valid      = lsu_valid_q;
   assign dmem_req_valid = req_valid_q;
   assign dmem_req_wen   = wen_q;
   assign dmem_req_addr  = {addr_q[XLEN-1:2], 2'b00};
   assign dmem_req_wdata = wdata_q;
   assign dmem_req_wmask = wmask_q;
   assign wb_data        = wb_data_q;
   assign lsu_err        = err_q;

   // Transaction FSM; all handshake outputs are registered alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         lsu_ready_q <= 1'b0;
         lsu_valid_q <= 1'b0;
         req_valid_q <= 1'b0;
         wb_data_q   <= '0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         ren_q       <= 1'b0;
         wen_q       <= 1'b0;
         width_q     <= 3'b000;
         addr_q      <= '0;
         wdata_q     <= '0;
         wmask_q     <= 4'b0000;
         alu_q       <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (exu_valid && lsu_ready_q) begin
                  ren_q       <= mem_ren;
                  wen_q       <= mem_wen;
                  width_q     <= mem_width;
                  addr_q      <= addr;
                  wdata_q     <= wdata;
                  // Loads never carry a byte mask onto the bus.
                  wmask_q     <= mem_wen ? wmask : 4'b0000;
                  alu_q       <= alu_res;
                  lsu_ready_q <= 1'b0;
                  if (!(mem_ren || mem_wen)) begin
                     state_q     <= ST_DONE;
                     wb_data_q   <= alu_res;
                     err_q       <= 1'b0;
                     lsu_valid_q <= 1'b1;
                  end else if (is_misaligned(mem_width, addr[1:0])) begin
                     state_q     <= ST_DONE;
                     wb_data_q   <= '0;
                     err_q       <= 1'b1;
                     lsu_valid_q <= 1'b1;
                  end else begin
                     state_q     <= ST_REQ;
                     req_valid_q <= 1'b1;
                     cnt_q       <= '0;
                  end
               end else begin
                  lsu_ready_q <= 1'b1;
               end
            end

            ST_REQ: begin
               cnt_q <= cnt_inc;
               if (dmem_req_ready) begin
                  state_q     <= ST_WAIT;
                  req_valid_q <= 1'b0;
               end else if (timeout_hit) begin
                  state_q     <= ST_DONE;
                  req_valid_q <= 1'b0;
                  wb_data_q   <= '0;
                  err_q       <= 1'b1;
                  lsu_valid_q <= 1'b1;
               end
            end

            ST_WAIT: begin
               cnt_q <= cnt_inc;
               if (dmem_resp_valid) begin
                  state_q     <= ST_DONE;
                  // A set write-enable wins, so ren&wen behaves as a store.
                  wb_data_q   <= (ren_q && !wen_q) ? load_data : alu_q;
                  err_q       <= 1'b0;
                  lsu_valid_q <= 1'b1;
               end else if (timeout_hit) begin
                  state_q     <= ST_DONE;
                  wb_data_q   <= '0;
                  err_q       <= 1'b1;
                  lsu_valid_q <= 1'b1;
               end
            end

            ST_DONE: begin
               if (wbu_ready) begin
                  state_q     <= ST_IDLE;
                  lsu_valid_q <= 1'b0;
                  lsu_ready_q <= 1'b1;
               end
            end

            default: begin
               state_q     <= ST_IDLE;
               lsu_ready_q <= 1'b0;
               lsu_valid_q <= 1'b0;
               req_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
